// File: rtl/axil_reg_slave.sv
// AXI4-Lite register bank responder: DEPTH word registers behind independent
// write (AW/W/B) and read (AR/R) state machines sharing one array.
module axil_reg_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                    s0_axi_aclk,
    input  logic                    s0_axi_areset,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
    input  logic                    s0_axi_awvalid,
    output logic                    s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
    input  logic                    s0_axi_wvalid,
    output logic                    s0_axi_wready,
    output logic [1:0]              s0_axi_bresp,
    output logic                    s0_axi_bvalid,
    input  logic                    s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
    input  logic                    s0_axi_arvalid,
    output logic                    s0_axi_arready,
    output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
    output logic [1:0]              s0_axi_rresp,
    output logic                    s0_axi_rvalid,
    input  logic                    s0_axi_rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } wstate_t;
    typedef enum logic { R_IDLE, R_DATA } rstate_t;

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return 32'(idx) < 32'(DEPTH);
    endfunction

    function automatic logic [MEM_AW-1:0] word_sel(input logic [IDX_W-1:0] idx);
        return idx[MEM_AW-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    wstate_t               wstate_q, wstate_d;
    logic                  aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [IDX_W-1:0]      awidx_q, awidx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  awready_q, awready_d, wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  mem_we;

    rstate_t               rstate_q, rstate_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic aw_hs, w_hs, ar_hs;
    assign aw_hs = s0_axi_awvalid && awready_q;
    assign w_hs  = s0_axi_wvalid && wready_q;
    assign ar_hs = s0_axi_arvalid && arready_q;

    // Byte offset bits never select anything; word addressing only.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = &{1'b0, s0_axi_awaddr[1:0], s0_axi_araddr[1:0]};

    always_comb begin
        wstate_d = wstate_q;
        aw_got_d = aw_got_q;
        w_got_d  = w_got_q;
        awidx_d  = awidx_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        mem_we   = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_got_d = 1'b1;
                    awidx_d  = s0_axi_awaddr[ADDR_WIDTH-1:2];
                end
                if (w_hs) begin
                    w_got_d = 1'b1;
                    wdata_d = s0_axi_wdata;
                    wstrb_d = s0_axi_wstrb;
                end
                if (aw_got_d && w_got_d) begin
                    wstate_d = W_RESP;
                    bvalid_d = 1'b1;
                    bresp_d  = in_range(awidx_d) ? RESP_OKAY : RESP_SLVERR;
                    mem_we   = in_range(awidx_d);
                end
            end
            W_RESP: begin
                if (s0_axi_bready) begin
                    wstate_d = W_IDLE;
                    bvalid_d = 1'b0;
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
        awready_d = (wstate_d == W_IDLE) && !aw_got_d;
        wready_d  = (wstate_d == W_IDLE) && !w_got_d;
    end

    // Read data is taken from the pre-edge array, so a same-edge write is not seen.
    always_comb begin
        rstate_d = rstate_q;
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        case (rstate_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rstate_d = R_DATA;
                    rvalid_d = 1'b1;
                    if (in_range(s0_axi_araddr[ADDR_WIDTH-1:2])) begin
                        rdata_d = mem_q[word_sel(s0_axi_araddr[ADDR_WIDTH-1:2])];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end
                end
            end
            R_DATA: begin
                if (s0_axi_rready) begin
                    rstate_d = R_IDLE;
                    rvalid_d = 1'b0;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
        arready_d = (rstate_d == R_IDLE);
    end

    always_ff @(posedge s0_axi_aclk) begin
        if (s0_axi_areset) begin
            wstate_q  <= W_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wstate_q  <= wstate_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awidx_q   <= awidx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            if (mem_we) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wstrb_d[b]) mem_q[word_sel(awidx_d)][8*b +: 8] <= wdata_d[8*b +: 8];
                end
            end
        end
    end

    assign s0_axi_awready = awready_q;
    assign s0_axi_wready  = wready_q;
    assign s0_axi_bvalid  = bvalid_q;
    assign s0_axi_bresp   = bresp_q;
    assign s0_axi_arready = arready_q;
    assign s0_axi_rvalid  = rvalid_q;
    assign s0_axi_rresp   = rresp_q;
    assign s0_axi_rdata   = rdata_q;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Bench for axil_reg_slave: B and R responses are predicted into queues when a
// transaction is driven and compared when the matching handshake is seen.
module tb_axil_reg_slave;

    logic        clk;
    logic        rst;
    logic [7:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [7:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    axil_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(8)) dut (
        .s0_axi_aclk   (clk),
        .s0_axi_areset (rst),
        .s0_axi_awaddr (awaddr),
        .s0_axi_awvalid(awvalid),
        .s0_axi_awready(awready),
        .s0_axi_wdata  (wdata),
        .s0_axi_wstrb  (wstrb),
        .s0_axi_wvalid (wvalid),
        .s0_axi_wready (wready),
        .s0_axi_bresp  (bresp),
        .s0_axi_bvalid (bvalid),
        .s0_axi_bready (bready),
        .s0_axi_araddr (araddr),
        .s0_axi_arvalid(arvalid),
        .s0_axi_arready(arready),
        .s0_axi_rdata  (rdata),
        .s0_axi_rresp  (rresp),
        .s0_axi_rvalid (rvalid),
        .s0_axi_rready (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic [1:0]  exp_b[$];
    rexp_t       exp_r[$];
    logic [31:0] exp_mem [8];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic addr_ok(input logic [7:0] a);
        return a[7:2] < 6'd8;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bvalid && bready) begin
                if (exp_b.size() == 0) chk("b_unexpected", 32'(bresp), 32'hFFFF_FFFF);
                else chk("bresp", 32'(bresp), 32'(exp_b.pop_front()));
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) begin
                    chk("r_unexpected", rdata, 32'hFFFF_FFFF);
                end else begin
                    rexp_t e;
                    e = exp_r.pop_front();
                    chk("rdata", rdata, e.data);
                    chk("rresp", 32'(rresp), 32'(e.resp));
                end
            end
        end
    end

    // gap > 0: W leads AW by gap cycles; gap < 0: AW leads W.
    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int gap, input int bhold);
        int  aw_start, w_start, cyc;
        bit  aw_done, w_done, aw_hs, w_hs;
        logic [1:0] exp_resp;
        aw_start = (gap > 0) ? gap : 0;
        w_start  = (gap < 0) ? -gap : 0;
        exp_resp = addr_ok(a) ? 2'b00 : 2'b10;
        exp_b.push_back(exp_resp);
        if (addr_ok(a)) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) exp_mem[a[4:2]][8*b +: 8] = d[8*b +: 8];
        end
        bready = (bhold == 0);
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 50) begin
            if (cyc == aw_start) begin awvalid = 1'b1; awaddr = a; end
            if (cyc == w_start) begin wvalid = 1'b1; wdata = d; wstrb = s; end
            @(negedge clk);
            if (w_done && !aw_done) begin
                chk("wready_drop", 32'(wready), 0);
                chk("bvalid_early", 32'(bvalid), 0);
            end
            if (aw_done && !w_done) begin
                chk("awready_drop", 32'(awready), 0);
                chk("bvalid_early", 32'(bvalid), 0);
            end
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin wvalid = 1'b0;  w_done = 1; end
            cyc++;
        end
        if (!(aw_done && w_done)) chk("wr_handshake_timeout", 0, 1);
        for (int k = 0; k < bhold; k++) begin
            if (k == 0) begin awvalid = 1'b1; awaddr = 8'h0C; end
            @(negedge clk);
            chk("bhold_bvalid", 32'(bvalid), 1);
            chk("bhold_bresp", 32'(bresp), 32'(exp_resp));
            chk("bhold_awready", 32'(awready), 0);
            chk("bhold_wready", 32'(wready), 0);
            @(posedge clk); #1;
            if (k == bhold - 1) begin awvalid = 1'b0; bready = 1'b1; end
        end
        @(negedge clk);
        chk("bvalid_lat", 32'(bvalid), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bvalid_clear", 32'(bvalid), 0);
        chk("awready_back", 32'(awready), 1);
        chk("wready_back", 32'(wready), 1);
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [7:0] a, input int rhold);
        rexp_t e;
        int    cyc;
        bit    hs;
        e.data = addr_ok(a) ? exp_mem[a[4:2]] : 32'h0;
        e.resp = addr_ok(a) ? 2'b00 : 2'b10;
        exp_r.push_back(e);
        rready  = (rhold == 0);
        arvalid = 1'b1;
        araddr  = a;
        hs = 0; cyc = 0;
        while (!hs && cyc < 50) begin
            @(negedge clk);
            hs = arvalid && arready;
            @(posedge clk); #1;
            cyc++;
        end
        arvalid = 1'b0;
        if (!hs) chk("rd_handshake_timeout", 0, 1);
        for (int k = 0; k < rhold; k++) begin
            @(negedge clk);
            chk("rhold_rvalid", 32'(rvalid), 1);
            chk("rhold_rdata", rdata, e.data);
            chk("rhold_rresp", 32'(rresp), 32'(e.resp));
            chk("rhold_arready", 32'(arready), 0);
            @(posedge clk); #1;
            if (k == rhold - 1) rready = 1'b1;
        end
        @(negedge clk);
        chk("rvalid_lat", 32'(rvalid), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rvalid_clear", 32'(rvalid), 0);
        chk("arready_back", 32'(arready), 1);
        @(posedge clk); #1;
    endtask

    task automatic read_all();
        for (int i = 0; i < 8; i++) do_read(8'(i * 4), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1;
        for (int i = 0; i < 8; i++) exp_mem[i] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 32'(awready), 0);
        chk("rst_wready", 32'(wready), 0);
        chk("rst_arready", 32'(arready), 0);
        chk("rst_bvalid", 32'(bvalid), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_bresp", 32'(bresp), 0);
        chk("rst_rresp", 32'(rresp), 0);
        chk("rst_rdata", rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_still_low", 32'(awready), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_up_aw", 32'(awready), 1);
        chk("ready_up_w", 32'(wready), 1);
        chk("ready_up_ar", 32'(arready), 1);
        @(posedge clk); #1;

        do_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0);
        do_read(8'h04, 0);
        do_write(8'h10, 32'h12345678, 4'hF, 3, 0);
        do_read(8'h10, 0);
        do_write(8'h18, 32'hA5A5_0F0F, 4'hF, -2, 0);
        do_read(8'h18, 0);
        do_write(8'h04, 32'h000000AA, 4'b0001, 0, 0);
        do_read(8'h04, 0);
        do_write(8'h1F, 32'h7700_0000, 4'b1000, 0, 0);
        do_write(8'h20, 32'hFFFFFFFF, 4'hF, 0, 0);
        do_read(8'hFC, 0);
        read_all();
        do_write(8'h08, 32'hCAFEF00D, 4'hF, 0, 5);
        do_read(8'h08, 5);
        read_all();

        bready = 1'b0;
        awvalid = 1'b1; awaddr = 8'h0C; wvalid = 1'b1; wdata = 32'h55AA55AA; wstrb = 4'hF;
        @(negedge clk);
        chk("abort_accept", 32'(awready && wready), 1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("abort_bvalid_pre", 32'(bvalid), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_bvalid", 32'(bvalid), 0);
        chk("abort_awready_low", 32'(awready), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_awready", 32'(awready), 1);
        chk("abort_wready", 32'(wready), 1);
        @(posedge clk); #1;
        bready = 1'b1;
        for (int i = 0; i < 8; i++) exp_mem[i] = '0;
        read_all();

        repeat (3) @(posedge clk);
        chk("b_queue_empty", 32'(exp_b.size()), 0);
        chk("r_queue_empty", 32'(exp_r.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
- AXI4-Lite responder (slave) holding a bank of DEPTH 32-bit registers.
- It is the endpoint that the bus block's m1 master port drives, so it terminates the write and read transactions the bus forwards.
- Write path (AW/W/B) and read path (AR/R) are independent FSMs that share one register array.
- Out-of-range accesses return SLVERR and have no side effects.

Parameters:
- DATA_WIDTH, 32, data bus width; must be a multiple of 8.
- ADDR_WIDTH, 8, byte address width.
- DEPTH, 8, number of registers; word-addressed at byte offsets 0,4,...,4*(DEPTH-1).

Ports:
- s0_axi_aclk  in  1  clock.
- s0_axi_areset  in  1  reset; synchronous, active-high.
- s0_axi_awaddr  in  ADDR_WIDTH  write address.
- s0_axi_awvalid  in  1  write address valid.
- s0_axi_awready  out  1  write address ready.
- s0_axi_wdata  in  DATA_WIDTH  write data.
- s0_axi_wstrb  in  DATA_WIDTH/8  byte enables.
- s0_axi_wvalid  in  1  write data valid.
- s0_axi_wready  out  1  write data ready.
- s0_axi_bresp  out  2  write response: 00 OKAY, 10 SLVERR.
- s0_axi_bvalid  out  1  write response valid.
- s0_axi_bready  in  1  write response ready.
- s0_axi_araddr  in  ADDR_WIDTH  read address.
- s0_axi_arvalid  in  1  read address valid.
- s0_axi_arready  out  1  read address ready.
- s0_axi_rdata  out  DATA_WIDTH  read data.
- s0_axi_rresp  out  2  read response: 00 OKAY, 10 SLVERR.
- s0_axi_rvalid  out  1  read data valid.
- s0_axi_rready  in  1  read data ready.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset state: all outputs 0 (awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata); all registers 0; both FSMs in idle.
- Readies are registered. They rise on the first clock edge after reset deasserts.
- Address decode: index = addr[ADDR_WIDTH-1:2]; addr[1:0] are ignored.
  - index < DEPTH: OKAY.
  - index >= DEPTH: SLVERR.
- Write FSM:
  - W_IDLE: awready=1, wready=1.
    - An AW handshake (awvalid&&awready) captures awaddr and drops awready.
    - A W handshake captures wdata/wstrb and drops wready.
    - AW and W may arrive in the same cycle or in either order, with any gap between them.
    - When both are captured (same cycle as the second handshake): go to W_RESP.
  - Entering W_RESP, on one edge:
    - Registers are updated: each byte lane i with wstrb[i]=1 is written; other lanes keep their value.
    - bvalid=1 and bresp are set.
    - SLVERR: no register changes.
    - So bvalid first appears one cycle after the completing handshake.
  - W_RESP:
    - bvalid and bresp are held stable until bready.
    - On the bvalid&&bready edge: bvalid=0, awready=1, wready=1, return to W_IDLE.
    - One outstanding write at most; no AW/W is accepted while in W_RESP.
- Read FSM:
  - R_IDLE: arready=1.
    - On an arvalid&&arready edge: arready=0; rdata/rresp/rvalid=1 registered on the same edge from the pre-edge array value; go to R_DATA.
    - Read latency: 1 cycle.
    - SLVERR: rdata=0.
  - R_DATA:
    - rdata, rresp and rvalid are held stable until rready.
    - On the rvalid&&rready edge: rvalid=0, arready=1, return to R_IDLE.
    - rdata keeps its last value after the handshake.
- Read/write collision: if an AR handshake happens on the same edge as a register update to the same index, the read returns the old value.
- Response and valid outputs never change while valid=1 and ready=0.
- Reset asserted mid-transaction: both FSMs abort to idle next edge; valids cleared; array cleared; no response is issued for aborted transactions.
- Width: wstrb is DATA_WIDTH/8 bits exactly. Response fields are 2 bits; only 00 and 10 are generated.

Test Plan:
- Reset, then write AW=0x04 with W=0xDEADBEEF and wstrb=4'hF in the same cycle, bready=1 -> bvalid the next cycle with bresp=00; reading 0x04 -> rdata=0xDEADBEEF, rresp=00, rvalid exactly 1 cycle after the AR handshake.
- W (0x12345678, strb 4'hF) presented 3 cycles before AW=0x10 -> wready drops after the W handshake; bvalid appears only after the AW handshake; reading 0x10 returns 0x12345678.
- Existing 0xDEADBEEF at 0x04, write 0x000000AA with strb 4'b0001 -> readback 0xDEADBEAA.
- Write to 0x20 and read from 0xFC (DEPTH=8) -> bresp=10 and rresp=10 with rdata=0; all 8 registers unchanged.
- bready held low for 5 cycles -> bvalid=1 and bresp stable throughout; awready/wready stay 0 and a new AW is not accepted. Same check for rready held low on the read path.
- Reset pulsed during W_RESP with bvalid=1 -> next cycle bvalid=0 and all registers read back 0; awready/wready=1 on the following edge.
